// File: rtl/node_ni.sv
// Network interface between a processing element and its leaf router in the tree NoC.
// TX FSM: IDLE | no queued word ; PACK | settle PACKDELAY cycles ; SEND | packet offered to router
module node_ni #(
    parameter int NODE_ADDR  = 1,
    parameter int WIDTH_pack = 20,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4,
    parameter int PACKDELAY  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pe_tx_valid,
    output logic                  pe_tx_ready,
    input  logic [4:0]            pe_tx_dest,
    input  logic [1:0]            pe_tx_type,
    input  logic [7:0]            pe_tx_data,
    output logic                  net_out_valid,
    input  logic                  net_out_ready,
    output logic [WIDTH_pack-1:0] net_out_pack,
    input  logic                  net_in_valid,
    output logic                  net_in_ready,
    input  logic [WIDTH_pack-1:0] net_in_pack,
    output logic                  pe_rx_valid,
    input  logic                  pe_rx_ready,
    output logic [4:0]            pe_rx_src,
    output logic [1:0]            pe_rx_type,
    output logic [7:0]            pe_rx_data,
    output logic [7:0]            drop_count
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int CW    = (PACKDELAY > 1) ? $clog2(PACKDELAY) : 1;
    localparam logic [4:0]    MY_ADDR   = 5'(NODE_ADDR);
    localparam logic [CW-1:0] PACK_LOAD = CW'(PACKDELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_SEND = 2'd2
    } tx_state_t;

    // ---------------- TX FIFO ----------------
    logic [14:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0]  tx_wr_ptr;
    logic [TX_AW:0]  tx_rd_ptr;
    logic [TX_AW:0]  tx_level;
    logic [14:0]     tx_head;
    logic            tx_full;
    logic            tx_empty;
    logic            tx_push;
    logic            tx_pop;
    logic            tx_drains;

    assign tx_level    = tx_wr_ptr - tx_rd_ptr;
    assign tx_empty    = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full     = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                         (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    assign pe_tx_ready = !tx_full;
    assign tx_push     = pe_tx_valid && pe_tx_ready;
    assign tx_head     = tx_mem[tx_rd_ptr[TX_AW-1:0]];
    // A push landing in the same cycle as the last pop keeps the FIFO non-empty.
    assign tx_drains   = (tx_level == {{TX_AW{1'b0}}, 1'b1}) && !tx_push;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= {pe_tx_type, pe_tx_dest, pe_tx_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t       state;
    tx_state_t       state_next;
    logic [CW-1:0]   pack_cnt;
    logic            pack_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!tx_empty) begin
                    state_next = S_PACK;
                end
            end
            S_PACK: begin
                if (pack_done) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (net_out_ready) begin
                    state_next = tx_drains ? S_IDLE : S_PACK;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        net_out_valid = (state == S_SEND);
        pack_done     = (state == S_PACK) && (pack_cnt == '0);
        tx_pop        = (state == S_SEND) && net_out_ready;
    end

    // Down-counter reloads whenever outside PACK, so every PACK entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_cnt <= PACK_LOAD;
        end else if (state != S_PACK) begin
            pack_cnt <= PACK_LOAD;
        end else if (pack_cnt != '0) begin
            pack_cnt <= pack_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net_out_pack <= '0;
        end else if (pack_done) begin
            net_out_pack <= {tx_head[14:13], tx_head[12:8], MY_ADDR, tx_head[7:0]};
        end
    end

    // ---------------- RX path ----------------
    logic [14:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0]  rx_wr_ptr;
    logic [RX_AW:0]  rx_rd_ptr;
    logic [14:0]     rx_head;
    logic            rx_full;
    logic            rx_empty;
    logic            rx_accept;
    logic            rx_match;
    logic            rx_push;
    logic            rx_pop;
    logic            rx_drop;

    assign rx_empty     = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full      = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                          (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
    assign net_in_ready = !rx_full;
    assign rx_accept    = net_in_valid && net_in_ready;
    assign rx_match     = (net_in_pack[17:13] == MY_ADDR);
    assign rx_push      = rx_accept && rx_match;
    assign rx_drop      = rx_accept && !rx_match;
    assign pe_rx_valid  = !rx_empty;
    assign rx_pop       = pe_rx_valid && pe_rx_ready;

    assign rx_head      = rx_mem[rx_rd_ptr[RX_AW-1:0]];
    assign pe_rx_type   = rx_head[14:13];
    assign pe_rx_src    = rx_head[12:8];
    assign pe_rx_data   = rx_head[7:0];

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[RX_AW-1:0]] <= {net_in_pack[19:18], net_in_pack[12:8], net_in_pack[7:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (rx_drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule
